// File: rtl/key_filter_core.sv
// Debounce filter for one active-low key: 2-FF synchroniser, stable-time FSM, registered level and strobes.
// Optional macro KEY_FILTER_EDGE_EN enables the key_press/key_release strobes; otherwise both are tied to 0.
module key_filter_core #(
    parameter int t = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_out,
    output logic key_press,
    output logic key_release
);

    localparam int CNT_W = $clog2(t + 1);
    // The transition fires on the t-th consecutive stable sample, when cnt holds t-2.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(t - 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        F_DOWN = 2'd1,
        DOWN   = 2'd2,
        F_UP   = 2'd3
    } state_t;

    logic             s1_r;
    logic             s2_r;
    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;

    // Two-stage synchroniser for the asynchronous key pin
    always_ff @(posedge clk) begin
        if (rst_n) begin
            s1_r <= 1'b1;
            s2_r <= 1'b1;
        end else begin
            s1_r <= key_in;
            s2_r <= s1_r;
        end
    end

    // Debounce FSM with stable-time counter and registered level output
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            key_out <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    key_out <= 1'b1;
                    cnt_r   <= {CNT_W{1'b0}};
                    if (!s2_r) begin
                        state_r <= F_DOWN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                F_DOWN: begin
                    if (s2_r) begin
                        state_r <= IDLE;
                        cnt_r   <= {CNT_W{1'b0}};
                    end else if (cnt_r == CNT_LAST) begin
                        state_r <= DOWN;
                        cnt_r   <= {CNT_W{1'b0}};
                        key_out <= 1'b0;
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                    end
                end
                DOWN: begin
                    key_out <= 1'b0;
                    cnt_r   <= {CNT_W{1'b0}};
                    if (s2_r) begin
                        state_r <= F_UP;
                    end else begin
                        state_r <= DOWN;
                    end
                end
                F_UP: begin
                    if (!s2_r) begin
                        state_r <= DOWN;
                        cnt_r   <= {CNT_W{1'b0}};
                    end else if (cnt_r == CNT_LAST) begin
                        state_r <= IDLE;
                        cnt_r   <= {CNT_W{1'b0}};
                        key_out <= 1'b1;
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= {CNT_W{1'b0}};
                    key_out <= 1'b1;
                end
            endcase
        end
    end

`ifdef KEY_FILTER_EDGE_EN
    logic press_r;
    logic release_r;

    // Strobes are registered alongside the key_out transition they mark
    always_ff @(posedge clk) begin
        if (rst_n) begin
            press_r   <= 1'b0;
            release_r <= 1'b0;
        end else begin
            press_r   <= (state_r == F_DOWN) && !s2_r && (cnt_r == CNT_LAST);
            release_r <= (state_r == F_UP)   &&  s2_r && (cnt_r == CNT_LAST);
        end
    end

    assign key_press   = press_r;
    assign key_release = release_r;
`else
    assign key_press   = 1'b0;
    assign key_release = 1'b0;
`endif

endmodule

// File: tb/tb_key_filter_core.sv
// Directed bench for key_filter_core with t=4; expected strobes follow KEY_FILTER_EDGE_EN.
module tb_key_filter_core;

    localparam int T = 4;
    localparam int LAT = T + 2;

`ifdef KEY_FILTER_EDGE_EN
    localparam logic EDGE = 1'b1;
`else
    localparam logic EDGE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic key_in;
    logic key_out;
    logic key_press;
    logic key_release;

    int vectors = 0;
    int miscompares = 0;
    int press_cnt;
    int release_cnt;
    logic lvl;

    key_filter_core #(.t(T)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_in      (key_in),
        .key_out     (key_out),
        .key_press   (key_press),
        .key_release (key_release)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic ko, input logic kp, input logic kr);
        chk({tag, ".key_out"}, {7'd0, key_out}, {7'd0, ko});
        chk({tag, ".key_press"}, {7'd0, key_press}, {7'd0, kp});
        chk({tag, ".key_release"}, {7'd0, key_release}, {7'd0, kr});
    endtask

    initial begin
        // 1: reset with key idle
        rst_n = 1'b1;
        key_in = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk_outs("reset", 1'b1, 1'b0, 1'b0);
        chk("reset.cnt", 8'(dut.cnt_r), 8'd0);
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk_outs("idle", 1'b1, 1'b0, 1'b0);
        end

        // 2: clean press, fall exactly LAT cycles after the edge
        key_in = 1'b0;
        for (int i = 1; i < LAT; i++) begin
            step();
            chk_outs("press_wait", 1'b1, 1'b0, 1'b0);
        end
        step();
        chk_outs("press_edge", 1'b0, EDGE, 1'b0);
        for (int i = LAT + 1; i <= 25; i++) begin
            step();
            chk_outs("press_hold", 1'b0, 1'b0, 1'b0);
        end

        // 3: clean release
        key_in = 1'b1;
        for (int i = 1; i < LAT; i++) begin
            step();
            chk_outs("rel_wait", 1'b0, 1'b0, 1'b0);
        end
        step();
        chk_outs("rel_edge", 1'b1, 1'b0, EDGE);
        for (int i = LAT + 1; i <= 25; i++) begin
            step();
            chk_outs("rel_hold", 1'b1, 1'b0, 1'b0);
        end

        // 4: bounces of 3 low cycles never reach key_out
        for (int r = 0; r < 5; r++) begin
            key_in = 1'b0;
            for (int i = 0; i < 3; i++) begin
                step();
                chk_outs("bounce_lo", 1'b1, 1'b0, 1'b0);
            end
            key_in = 1'b1;
            for (int i = 0; i < 3; i++) begin
                step();
                chk_outs("bounce_hi", 1'b1, 1'b0, 1'b0);
            end
        end
        for (int i = 0; i < 10; i++) begin
            step();
            chk_outs("bounce_settle", 1'b1, 1'b0, 1'b0);
        end

        // 5: alternating press/release, key_out follows key_in after LAT cycles
        press_cnt = 0;
        release_cnt = 0;
        lvl = 1'b1;
        for (int p = 0; p < 10; p++) begin
            key_in = lvl ^ 1'b1;
            for (int i = 1; i <= 25; i++) begin
                step();
                chk("alt.key_out", {7'd0, key_out}, {7'd0, (i >= LAT) ? key_in : lvl});
                chk("alt.exclusive", {7'd0, key_press & key_release}, 8'd0);
                if (key_press) press_cnt++;
                if (key_release) release_cnt++;
            end
            lvl = key_in;
        end
        chk("alt.press_cnt", 8'(press_cnt), EDGE ? 8'd5 : 8'd0);
        chk("alt.release_cnt", 8'(release_cnt), EDGE ? 8'd5 : 8'd0);

        // 6: reset asserted while filtering a press at cnt=2
        key_in = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("mid.state", 8'(dut.state_r), 8'd1);
        chk("mid.cnt", 8'(dut.cnt_r), 8'd2);
        chk_outs("mid", 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        chk_outs("mid_rst", 1'b1, 1'b0, 1'b0);
        chk("mid_rst.cnt", 8'(dut.cnt_r), 8'd0);
        chk("mid_rst.state", 8'(dut.state_r), 8'd0);
        key_in = 1'b1;
        step();
        rst_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_outs("post_rst", 1'b1, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
